// File: rtl/mandel_pixel_dispatcher.sv
// mandel_pixel_dispatcher
//   Walks an H_ACTIVE x V_ACTIVE pixel grid in raster order, produces the
//   Q4.28 complex coordinate c for each pixel, hands it to the Mandelbrot
//   calculator one pixel at a time (start/ready handshake), catches the
//   returned RGB333 colour and writes it to the display buffer at the
//   linear address y*H_ACTIVE + x.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   reset          synchronous, active-high
//   frame_start    one-cycle request to render a frame (ignored while busy)
//   continuous     1 = restart a new frame automatically after frame_done
//   busy           high from frame acceptance until frame_done
//   frame_done     one-cycle pulse after the last pixel is written
//   calc_ready     calculator can accept a new pixel
//   calc_start     one-cycle start pulse to the calculator
//   real_part      c real, held from calc_start until the result is taken
//   imaginary_part c imag, same stability rule
//   calc_out_ready calculator result valid (one-cycle pulse)
//   calc_colour    RGB333 colour from the calculator
//   wr_en          display buffer write strobe
//   wr_addr        display buffer linear address
//   wr_data        colour to write
module mandel_pixel_dispatcher #(
  parameter int unsigned         H_ACTIVE = 64,
  parameter int unsigned         V_ACTIVE = 48,
  parameter int unsigned         COORD_W  = 32,
  parameter logic [COORD_W-1:0]  X_START  = 32'hE000_0000,
  parameter logic [COORD_W-1:0]  Y_START  = 32'hEE00_0000,
  parameter logic [COORD_W-1:0]  X_STEP   = 32'h00C0_0000,
  parameter logic [COORD_W-1:0]  Y_STEP   = 32'h00C0_0000,
  parameter int unsigned         AW       = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               continuous,
  output logic               busy,
  output logic               frame_done,
  input  logic               calc_ready,
  output logic               calc_start,
  output logic [COORD_W-1:0] real_part,
  output logic [COORD_W-1:0] imaginary_part,
  input  logic               calc_out_ready,
  input  logic [8:0]         calc_colour,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [8:0]         wr_data
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // Start must fire in the same cycle calc_ready is seen in ISSUE, so it is
  // decoded from the registered state rather than registered itself.
  always_comb begin
    calc_start = (state == ISSUE) && calc_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      x              <= '0;
      y              <= '0;
      wr_addr        <= '0;
      real_part      <= X_START;
      imaginary_part <= Y_START;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      wr_en          <= 1'b0;
      wr_data        <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state          <= ISSUE;
            busy           <= 1'b1;
            x              <= '0;
            y              <= '0;
            wr_addr        <= '0;
            real_part      <= X_START;
            imaginary_part <= Y_START;
          end
        end
        ISSUE: begin
          if (calc_ready) state <= WAIT;
        end
        WAIT: begin
          // Result is taken here only; a simultaneous calc_ready is left
          // for the next ISSUE visit.
          if (calc_out_ready) begin
            wr_data <= calc_colour;
            wr_en   <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (x != X_LAST) begin
            x         <= x + XW'(1);
            wr_addr   <= wr_addr + AW'(1);
            real_part <= real_part + X_STEP;
            state     <= ISSUE;
          end else if (y != Y_LAST) begin
            x              <= '0;
            y              <= y + YW'(1);
            wr_addr        <= wr_addr + AW'(1);
            real_part      <= X_START;
            imaginary_part <= imaginary_part + Y_STEP;
            state          <= ISSUE;
          end else begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          x              <= '0;
          y              <= '0;
          wr_addr        <= '0;
          real_part      <= X_START;
          imaginary_part <= Y_START;
          if (continuous) begin
            state <= ISSUE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_pixel_dispatcher.sv
module tb_mandel_pixel_dispatcher;

  localparam int H    = 64;
  localparam int V    = 48;
  localparam int NPIX = H * V;
  localparam int AW   = 12;
  localparam logic [31:0] XS    = 32'hE000_0000;
  localparam logic [31:0] YS    = 32'hEE00_0000;
  localparam logic [31:0] XSTEP = 32'h00C0_0000;
  localparam logic [31:0] YSTEP = 32'h00C0_0000;

  logic          clk = 1'b0;
  logic          reset, frame_start, continuous;
  logic          busy, frame_done;
  logic          calc_ready, calc_start;
  logic [31:0]   real_part, imaginary_part;
  logic          calc_out_ready;
  logic [8:0]    calc_colour;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;

  always #5 clk = ~clk;

  mandel_pixel_dispatcher #(
    .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(32),
    .X_START(XS), .Y_START(YS), .X_STEP(XSTEP), .Y_STEP(YSTEP), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .continuous(continuous),
    .busy(busy), .frame_done(frame_done),
    .calc_ready(calc_ready), .calc_start(calc_start),
    .real_part(real_part), .imaginary_part(imaginary_part),
    .calc_out_ready(calc_out_ready), .calc_colour(calc_colour),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model state (monitor) ----------------
  logic        mon_en = 1'b0;
  logic        outstanding = 1'b0;  // pixel issued, result not yet taken
  logic        due = 1'b0;          // result taken last cycle, write expected now
  int          due_addr;
  logic [8:0]  due_data;
  int          starts = 0;          // calc_start pulses since monitor enable
  int          cur_idx;
  logic [31:0] cur_re, cur_im;
  int          writes = 0;
  int          frame_writes = 0;
  int          fd_cnt = 0;
  logic        prev_fd = 1'b0, prev_cont = 1'b0;
  logic        start_seen = 1'b0;

  task automatic monitor();
    int ix, iy;
    logic [31:0] er, ei;
    if (!mon_en) begin
      outstanding  = 1'b0;
      due          = 1'b0;
      starts       = 0;
      frame_writes = 0;
      prev_fd      = 1'b0;
      start_seen   = 1'b0;
    end else begin
      if (due) begin
        check("wr_en_latency", 32'(wr_en), 32'd1);
        check("wr_addr", 32'(wr_addr), 32'(due_addr));
        check("wr_data", 32'(wr_data), 32'(due_data));
        writes++;
        frame_writes++;
        due = 1'b0;
      end else begin
        check("no_spurious_wr", 32'(wr_en), 32'd0);
      end
      if (prev_fd) check("busy_after_done", 32'(busy), 32'(prev_cont));
      if (frame_done) begin
        check("busy_at_done", 32'(busy), 32'd1);
        check("writes_per_frame", 32'(frame_writes), 32'(NPIX));
        frame_writes = 0;
        fd_cnt++;
      end
      prev_fd   = frame_done;
      prev_cont = continuous;
      if (outstanding) begin
        check("re_stable", real_part, cur_re);
        check("im_stable", imaginary_part, cur_im);
        if (calc_out_ready) begin
          due         = 1'b1;
          due_addr    = cur_idx;
          due_data    = calc_colour;
          outstanding = 1'b0;
        end
      end
      start_seen = calc_start;
      if (calc_start) begin
        check("one_at_a_time", 32'(outstanding), 32'd0);
        cur_idx = starts % NPIX;
        ix = cur_idx % H;
        iy = cur_idx / H;
        er = XS + 32'(ix) * XSTEP;
        ei = YS + 32'(iy) * YSTEP;
        check("start_re", real_part, er);
        check("start_im", imaginary_part, ei);
        check("busy_at_start", 32'(busy), 32'd1);
        cur_re      = er;
        cur_im      = ei;
        outstanding = 1'b1;
        starts++;
      end
    end
  endtask

  // ---------------- calculator model ----------------
  logic       tbl_mode = 1'b1;
  logic       ready_rand = 1'b0, lat_rand = 1'b0, col_rand = 1'b0, inject = 1'b0;
  logic       pend = 1'b0;
  int         cd = 0;
  logic [8:0] pend_col;
  int         cidx = 0;

  task automatic calc_drive();
    if (start_seen) begin
      if (!tbl_mode) begin
        pend     = 1'b1;
        cd       = lat_rand ? int'($urandom_range(1, 4)) : 3;
        pend_col = col_rand ? 9'($urandom) : 9'(cidx % NPIX);
      end
      cidx++;
    end
    if (!tbl_mode) begin
      calc_ready     = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      calc_out_ready = 1'b0;
      if (pend) begin
        cd--;
        if (cd == 0) begin
          calc_out_ready = 1'b1;
          calc_colour    = pend_col;
          pend           = 1'b0;
        end
      end else if (inject && $urandom_range(0, 31) == 0) begin
        calc_out_ready = 1'b1;
        calc_colour    = 9'($urandom);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    calc_drive();
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    advance();
  endtask

  task automatic wait_fd(input int base, input int want, input string nm);
    int n = 0;
    while (fd_cnt - base < want && n < 40000) begin
      tick();
      n++;
    end
    check(nm, 32'(fd_cnt - base), 32'(want));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        chk;
    logic        rst, fs, rdy, ordy;
    logic [8:0]  col;
    logic        busy, cs, we, fd;
    logic [11:0] addr;
    logic [8:0]  data;
    logic [31:0] re, im;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int s0, w0, n;

    //            chk  rst  fs   rdy  ordy col     busy cs   we   fd   addr  data    re            im
    tbl[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,9'h000,1'b0,1'b0,1'b0,1'b0,12'd0,9'h000,XS,          YS};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,9'h000,1'b0,1'b0,1'b0,1'b0,12'd0,9'h000,XS,          YS};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,9'h1FF,1'b0,1'b0,1'b0,1'b0,12'd0,9'h000,XS,          YS};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,9'h000,1'b0,1'b0,1'b0,1'b0,12'd0,9'h000,XS,          YS};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,9'h000,1'b1,1'b1,1'b0,1'b0,12'd0,9'h000,XS,          YS};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,9'h000,1'b1,1'b0,1'b0,1'b0,12'd0,9'h000,XS,          YS};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,9'h1A5,1'b1,1'b0,1'b0,1'b0,12'd0,9'h000,XS,          YS};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,9'h000,1'b1,1'b0,1'b1,1'b0,12'd0,9'h1A5,XS,          YS};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,9'h000,1'b1,1'b0,1'b0,1'b0,12'd1,9'h1A5,32'hE0C00000,YS};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,9'h0F0,1'b1,1'b0,1'b0,1'b0,12'd1,9'h1A5,32'hE0C00000,YS};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,9'h000,1'b1,1'b0,1'b0,1'b0,12'd1,9'h1A5,32'hE0C00000,YS};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0,9'h000,1'b1,1'b1,1'b0,1'b0,12'd1,9'h1A5,32'hE0C00000,YS};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1,9'h055,1'b1,1'b0,1'b0,1'b0,12'd1,9'h1A5,32'hE0C00000,YS};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,9'h000,1'b1,1'b0,1'b1,1'b0,12'd1,9'h055,32'hE0C00000,YS};

    reset = 1'b1; frame_start = 1'b0; continuous = 1'b0;
    calc_ready = 1'b0; calc_out_ready = 1'b0; calc_colour = '0;

    for (int i = 0; i < 14; i++) begin
      reset          = tbl[i].rst;
      frame_start    = tbl[i].fs;
      calc_ready     = tbl[i].rdy;
      calc_out_ready = tbl[i].ordy;
      calc_colour    = tbl[i].col;
      mon_en         = !tbl[i].rst;
      @(negedge clk);
      monitor();
      if (tbl[i].chk) begin
        check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
        check($sformatf("v%0d_calc_start", i), 32'(calc_start), 32'(tbl[i].cs));
        check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].we));
        check($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].fd));
        check($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].addr));
        check($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].data));
        check($sformatf("v%0d_re", i), real_part, tbl[i].re);
        check($sformatf("v%0d_im", i), imaginary_part, tbl[i].im);
      end
      advance();
    end

    // Pixel 2 waits in ISSUE with calc_ready low for 10 cycles.
    calc_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      calc_ready = 1'b0;
      @(negedge clk);
      monitor();
      check("hold_no_start", 32'(calc_start), 32'd0);
      check("hold_re", real_part, 32'hE1800000);
      check("hold_im", imaginary_part, YS);
      advance();
    end
    calc_ready = 1'b1;
    @(negedge clk);
    monitor();
    check("hold_release_start", 32'(calc_start), 32'd1);
    tbl_mode   = 1'b0;
    ready_rand = 1'b1;
    advance();

    // Rest of frame 1: latency 3, colour = pixel index[8:0].
    wait_fd(0, 1, "frame1_done");
    repeat (4) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("frame1_writes", 32'(writes), 32'(NPIX));

    // Two frames with continuous=1 then continuous=0, random timing.
    lat_rand = 1'b1; col_rand = 1'b1; inject = 1'b1;
    continuous = 1'b1;
    s0 = fd_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_fd(s0, 1, "cont_first_done");
    continuous = 1'b0;
    wait_fd(s0, 2, "cont_second_done");
    repeat (4) tick();
    check("cont_idle_busy", 32'(busy), 32'd0);
    check("cont_total_writes", 32'(writes), 32'(3 * NPIX));

    // Reset while in WAIT at pixel 100.
    lat_rand = 1'b0; col_rand = 1'b0; inject = 1'b0; ready_rand = 1'b0;
    cidx = 0;
    s0 = starts;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (starts - s0 < 101 && n < 2000) begin
      tick();
      n++;
    end
    check("reach_pixel100", 32'(starts - s0), 32'd101);
    reset  = 1'b1;
    mon_en = 1'b0;
    cidx   = 0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    monitor();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_calc_start", 32'(calc_start), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_re", real_part, XS);
    check("rst_im", imaginary_part, YS);
    mon_en = 1'b1;
    advance();
    w0 = writes;
    repeat (6) tick();
    check("late_result_no_write", 32'(writes - w0), 32'd0);

    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (writes - w0 < 8 && n < 2000) begin
      tick();
      n++;
    end
    check("restart_writes", 32'(writes - w0), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mandel_pixel_dispatcher.md
Name: mandel_pixel_dispatcher

Overview:
- Upstream/downstream companion to the Mandelbrot calculator.
- Walks the H_ACTIVE x V_ACTIVE pixel grid in raster order and generates a fixed-point complex coordinate (c) per pixel.
- Issues exactly one pixel at a time to the calculator through a start/ready handshake, catches the colour result, and writes it into the display buffer at the matching linear address.
- Replaces the ad-hoc address-clock gating and free-running write counters in the top level.

Parameters:
- H_ACTIVE, 64, pixels per line.
- V_ACTIVE, 48, lines per frame.
- COORD_W, 32, width of real/imag coordinates (two's complement Q4.28).
- X_START, 32'hE000_0000, real value of column 0 (-2.0).
- Y_START, 32'hEE00_0000, imag value of line 0 (-1.125).
- X_STEP, 32'h00C0_0000, real increment per column (0.046875).
- Y_STEP, 32'h00C0_0000, imag increment per line (0.046875).
- AW, $clog2(H_ACTIVE*V_ACTIVE), display buffer address width.

Ports:
- clk  in  1  system clock (all logic on posedge)
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle request to render a frame
- continuous  in  1  1 = auto-restart a new frame after each completed frame
- busy  out  1  high from frame acceptance until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel is written
- calc_ready  in  1  calculator can accept a new pixel
- calc_start  out  1  one-cycle start pulse to the calculator
- real_part  out  COORD_W  c real, stable from calc_start until the result is taken
- imaginary_part  out  COORD_W  c imag, same stability rule
- calc_out_ready  in  1  calculator result valid (one-cycle pulse)
- calc_colour  in  9  RGB333 colour from the calculator
- wr_en  out  1  display buffer write strobe
- wr_addr  out  AW  linear address = y*H_ACTIVE + x
- wr_data  out  9  colour to write

Behaviour:
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- Reset (sync, any state, mid-frame included):
  - state = IDLE; x = y = 0; wr_addr = 0.
  - real_part = X_START; imaginary_part = Y_START.
  - busy, frame_done, calc_start, wr_en = 0; wr_data = 0.
  - Any in-flight calculator result is discarded.
- IDLE:
  - On frame_start=1, go to ISSUE next cycle with busy=1 and coordinates at (X_START, Y_START).
  - Otherwise stay in IDLE.
- ISSUE:
  - When calc_ready=1, assert calc_start for exactly that one cycle and go to WAIT.
  - While calc_ready=0, wait with calc_start=0.
- WAIT:
  - On calc_out_ready=1, register calc_colour into wr_data and go to WRITE.
  - real_part/imaginary_part do not change in WAIT.
- WRITE (one cycle): wr_en=1 with the current wr_addr and wr_data, then advance:
  - x < H_ACTIVE-1: x+1, wr_addr+1, real_part += X_STEP, go to ISSUE.
  - x == H_ACTIVE-1 and y < V_ACTIVE-1: x=0, y+1, wr_addr+1, real_part = X_START, imaginary_part += Y_STEP, go to ISSUE.
  - Last pixel (x == H_ACTIVE-1, y == V_ACTIVE-1): go to DONE.
- DONE (one cycle):
  - frame_done=1.
  - Reload x, y, wr_addr, real_part and imaginary_part to their start values.
  - continuous=1: go to ISSUE with busy kept high.
  - continuous=0: go to IDLE with busy=0.
- Latency:
  - frame_start sampled at cycle N → earliest calc_start at N+1.
  - calc_out_ready at M → wr_en at M+1 → earliest next calc_start at M+2.
- Arithmetic:
  - Coordinate adds are COORD_W-bit modulo 2^COORD_W; no saturation.
  - wr_addr never exceeds H_ACTIVE*V_ACTIVE-1.
- Ignored inputs:
  - frame_start while busy=1 is ignored (no restart, no queueing).
  - calc_out_ready outside WAIT is ignored; nothing is written.
  - calc_ready outside ISSUE is ignored.
- Simultaneous events: calc_out_ready and calc_ready both high in WAIT → take the result only; issue happens on the later ISSUE visit.
- Exactly H_ACTIVE*V_ACTIVE wr_en pulses per frame, addresses strictly ascending 0..H_ACTIVE*V_ACTIVE-1.

Test Plan:
- Reset then single frame_start, calc model returns colour = wr_addr[8:0] 3 cycles after each calc_start → 3072 writes, address k carries data k mod 512, one frame_done, busy falls the cycle after frame_done.
- Check coordinates at calc_start → pixel 0 = (E000_0000, EE00_0000); pixel 1 real = E0C0_0000; pixel 64 = (E000_0000, EEC0_0000); pixel 3071 = (0F40_0000, 1140_0000).
- Hold calc_ready=0 for 10 cycles in ISSUE → no calc_start, coordinates stable; raise calc_ready → single calc_start the same cycle.
- Inject calc_out_ready in IDLE and ISSUE, and pulse frame_start mid-frame → no extra wr_en, no restart, address sequence unchanged.
- continuous=1 over two frames → frame_done pulses twice; second frame's first write at address 0, at coordinates (E000_0000, EE00_0000).
- Assert reset while in WAIT at pixel 100 → next cycle all outputs at reset values; a late calc_out_ready produces no write; a new frame_start restarts at address 0.
